// File: rtl/regfile_dump.sv
// Debug read-out engine: walks registers START_REG..END_REG through one regfile
// read port and streams (index, value) words on a valid/ready interface.
module regfile_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int START_REG  = 0,
    parameter int END_REG    = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(START_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(END_REG);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  handshake;
    logic                  last_word;

    assign handshake = out_valid && out_ready;
    assign last_word = (cnt == LAST_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort outranks both a pending handshake and a start arriving in IDLE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                rd_addr    = cnt;
                state_next = abort ? IDLE : SEND;
            end
            SEND: begin
                busy    = 1'b1;
                rd_addr = cnt;
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake) begin
                    state_next = last_word ? IDLE : READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The word is captured on the READ edge, so a same-edge regfile write is not seen
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= FIRST_REG;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cnt <= FIRST_REG;
                    end
                end
                READ: begin
                    if (!abort) begin
                        out_valid <= 1'b1;
                        out_index <= cnt;
                        out_data  <= rd_data;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        if (last_word) begin
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: three instances (ranges 1..3, 0..0, 0..31) on a shared
// regfile, checked every cycle against a word-level model plus directed literals.
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start     [3];
    logic          abort     [3];
    logic          out_ready [3];
    logic [AW-1:0] rd_addr   [3];
    logic [AW-1:0] out_index [3];
    logic [DW-1:0] rd_data   [3];
    logic [DW-1:0] out_data  [3];
    logic          out_valid [3];
    logic          busy      [3];
    logic          done      [3];

    logic [DW-1:0] regs [32];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) regs[wr_addr] <= wr_data;
    end

    assign rd_data[0] = regs[rd_addr[0]];
    assign rd_data[1] = regs[rd_addr[1]];
    assign rd_data[2] = regs[rd_addr[2]];

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(1), .END_REG(3)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_index(out_index[0]), .out_data(out_data[0]), .busy(busy[0]), .done(done[0]));

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(0), .END_REG(0)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_index(out_index[1]), .out_data(out_data[1]), .busy(busy[1]), .done(done[1]));

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(0), .END_REG(31)) dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .rd_addr(rd_addr[2]),
        .rd_data(rd_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_index(out_index[2]), .out_data(out_data[2]), .busy(busy[2]), .done(done[2]));

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic s, input logic a, input logic r);
        start[k]     = s;
        abort[k]     = a;
        out_ready[k] = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic writeReg(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        nextCycle();
        wr_en   = 1'b0;
    endtask

    // Word-level reference: a dump is "active" with a current index; each word
    // takes one capture cycle then is shown until accepted.
    int            first_r [3] = '{1, 0, 0};
    int            last_r  [3] = '{3, 0, 31};
    bit            m_busy  [3];
    bit            m_word  [3];
    bit            m_done  [3];
    int            m_idx   [3];
    logic [AW-1:0] m_oi    [3];
    logic [DW-1:0] m_od    [3];
    bit            model_ok = 1'b0;
    int            word_cnt [3] = '{0, 0, 0};
    int            done_cnt [3] = '{0, 0, 0};
    logic [AW+DW-1:0] q_b[$];
    logic [AW+DW-1:0] q_c[$];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (model_ok) begin
                checkOutput($sformatf("busy%0d", k), 64'(busy[k]), 64'(m_busy[k]));
                checkOutput($sformatf("rd_addr%0d", k), 64'(rd_addr[k]), 64'(m_busy[k] ? m_idx[k] : 0));
                checkOutput($sformatf("out_valid%0d", k), 64'(out_valid[k]), 64'(m_word[k]));
                checkOutput($sformatf("out_index%0d", k), 64'(out_index[k]), 64'(m_oi[k]));
                checkOutput($sformatf("out_data%0d", k), 64'(out_data[k]), 64'(m_od[k]));
                checkOutput($sformatf("done%0d", k), 64'(done[k]), 64'(m_done[k]));
                if (done[k]) done_cnt[k]++;
                if (!rst && m_busy[k] && m_word[k] && !abort[k] && out_ready[k]) begin
                    word_cnt[k]++;
                    if (k == 1) q_b.push_back({out_index[k], out_data[k]});
                    if (k == 2) q_c.push_back({out_index[k], out_data[k]});
                end
            end
            if (rst) begin
                m_busy[k] = 1'b0;
                m_word[k] = 1'b0;
                m_done[k] = 1'b0;
                m_oi[k]   = '0;
                m_od[k]   = '0;
                m_idx[k]  = first_r[k];
            end else begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (start[k] && !abort[k]) begin
                        m_busy[k] = 1'b1;
                        m_word[k] = 1'b0;
                        m_idx[k]  = first_r[k];
                    end
                end else if (abort[k]) begin
                    m_busy[k] = 1'b0;
                    m_word[k] = 1'b0;
                end else if (!m_word[k]) begin
                    m_word[k] = 1'b1;
                    m_oi[k]   = AW'(m_idx[k]);
                    m_od[k]   = regs[m_idx[k]];
                end else if (out_ready[k]) begin
                    m_word[k] = 1'b0;
                    if (m_idx[k] == last_r[k]) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                    end else begin
                        m_idx[k]++;
                    end
                end
            end
        end
        if (rst) model_ok = 1'b1;
    end

    bit            s1_valid [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    bit            s1_busy  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit            s1_done  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int            s1_index [8] = '{0, 0, 1, 0, 2, 0, 3, 0};
    logic [DW-1:0] s1_data  [8] = '{0, 0, 32'h1511, 0, 32'h123, 0, 32'h312, 0};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wbase;
        int dbase;
        bit finished;
        rst   = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        midCycle();
        checkOutput("reset_busy", 64'(busy[0]), 64'(0));
        checkOutput("reset_valid", 64'(out_valid[0]), 64'(0));
        nextCycle();
        for (int n = 0; n < 32; n++) writeReg(n, DW'(n) * 32'h01010101);
        writeReg(1, 32'h00001511);
        writeReg(2, 32'h00000123);
        writeReg(3, 32'h00000312);

        // Scenario 1: full 1..3 dump without backpressure
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            midCycle();
            checkOutput("s1_valid", 64'(out_valid[0]), 64'(s1_valid[c]));
            checkOutput("s1_busy", 64'(busy[0]), 64'(s1_busy[c]));
            checkOutput("s1_done", 64'(done[0]), 64'(s1_done[c]));
            if (s1_valid[c]) begin
                checkOutput("s1_index", 64'(out_index[0]), 64'(s1_index[c]));
                checkOutput("s1_data", 64'(out_data[0]), 64'(s1_data[c]));
            end
            nextCycle();
        end

        // Scenario 2: first word held for 5 cycles of backpressure
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            midCycle();
            if (c >= 2 && c <= 7) begin
                checkOutput("s2_hold_valid", 64'(out_valid[0]), 64'(1));
                checkOutput("s2_hold_index", 64'(out_index[0]), 64'(1));
                checkOutput("s2_hold_data", 64'(out_data[0]), 64'(32'h1511));
                checkOutput("s2_hold_rd_addr", 64'(rd_addr[0]), 64'(1));
            end
            if (c == 9) checkOutput("s2_word2", 64'({out_valid[0], out_index[0], out_data[0]}),
                                    64'({1'b1, 5'd2, 32'h123}));
            if (c == 11) checkOutput("s2_word3", 64'({out_valid[0], out_index[0], out_data[0]}),
                                     64'({1'b1, 5'd3, 32'h312}));
            if (c == 12) checkOutput("s2_done", 64'(done[0]), 64'(1));
            nextCycle();
            if (c == 6) out_ready[0] = 1'b1;
        end

        // Scenario 3: write to r2 on its own capture edge, then dump again
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            wr_en   = (c == 3);
            wr_addr = 5'd2;
            wr_data = 32'hDEADBEEF;
            midCycle();
            if (c == 4) checkOutput("s3_old_value", 64'({out_index[0], out_data[0]}), 64'({5'd2, 32'h123}));
            nextCycle();
        end
        wr_en = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            midCycle();
            if (c == 4) checkOutput("s3_new_value", 64'({out_index[0], out_data[0]}), 64'({5'd2, 32'hDEADBEEF}));
            nextCycle();
        end

        // Scenario 4a: abort during SEND of index 2, with ready also high
        dbase = done_cnt[0];
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, 1'b0, c == 4, 1'b1);
            midCycle();
            if (c == 4) checkOutput("s4_abort_at", 64'({out_valid[0], out_index[0]}), 64'({1'b1, 5'd2}));
            if (c == 5) checkOutput("s4_after_abort", 64'({out_valid[0], busy[0]}), 64'(0));
            nextCycle();
        end
        checkOutput("s4_no_done", 64'(done_cnt[0] - dbase), 64'(0));

        // Scenario 4b: start pulses while busy are ignored
        wbase = word_cnt[0];
        dbase = done_cnt[0];
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(0, (c == 2 || c == 3 || c == 5), 1'b0, 1'b1);
            midCycle();
            if (c == 8) checkOutput("s4_no_restart", 64'(busy[0]), 64'(0));
            nextCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        checkOutput("s4_word_count", 64'(word_cnt[0] - wbase), 64'(3));
        checkOutput("s4_done_count", 64'(done_cnt[0] - dbase), 64'(1));

        // Scenario 4c: reset while a word is held
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        midCycle();
        checkOutput("s4_pre_reset_valid", 64'(out_valid[0]), 64'(1));
        nextCycle();
        rst = 1'b0;
        midCycle();
        checkOutput("s4_reset_outputs",
                    64'({out_valid[0], busy[0], done[0], rd_addr[0], out_index[0], out_data[0]}), 64'(0));
        nextCycle();

        // Scenario 5: single-register range
        q_b.delete();
        dbase = done_cnt[1];
        applyStimulus(1, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            midCycle();
            if (c == 2) checkOutput("s5_word", 64'({out_valid[1], out_index[1], out_data[1]}), 64'({1'b1, 37'd0}));
            if (c == 3) checkOutput("s5_done", 64'({done[1], out_valid[1]}), 64'({1'b1, 1'b0}));
            nextCycle();
        end
        checkOutput("s5_word_count", 64'(q_b.size()), 64'(1));
        checkOutput("s5_done_count", 64'(done_cnt[1] - dbase), 64'(1));

        // Scenario 6: full 0..31 range with ready toggling every cycle
        for (int n = 0; n < 32; n++) writeReg(n, DW'(n) * 32'h01010101);
        q_c.delete();
        dbase = done_cnt[2];
        applyStimulus(2, 1'b1, 1'b0, 1'b1);
        nextCycle();
        finished = 1'b0;
        for (int c = 1; c < 400 && !finished; c++) begin
            applyStimulus(2, 1'b0, 1'b0, (c % 2) == 0);
            midCycle();
            if (done[2]) finished = 1'b1;
            nextCycle();
        end
        checkOutput("s6_completed", 64'(finished), 64'(1));
        for (int c = 0; c < 5; c++) nextCycle();
        checkOutput("s6_done_count", 64'(done_cnt[2] - dbase), 64'(1));
        checkOutput("s6_word_count", 64'(q_c.size()), 64'(32));
        if (q_c.size() == 32) begin
            checkOutput("s6_word5", 64'(q_c[5]), 64'({5'd5, 32'h05050505}));
            for (int i = 0; i < 32; i++)
                checkOutput($sformatf("s6_word_%0d", i), 64'(q_c[i]), 64'({AW'(i), DW'(i) * 32'h01010101}));
        end
        applyStimulus(2, 1'b0, 1'b0, 1'b0);

        // Random phase: every instance checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++)
                applyStimulus(k, ($urandom % 6) == 0, ($urandom % 25) == 0, ($urandom % 2) == 1);
            wr_en   = ($urandom % 4) == 0;
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            rst     = ($urandom % 300) == 0;
            nextCycle();
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine for the CPU register file.
- After a start pulse it walks a contiguous range of registers through one regfile read port.
- Each register index and value is presented as one word on a valid/ready output stream, toward the trace/UART logger.
- It is the reading end of the regfile's write interface: it dumps what the core or bench has written.

Parameters:
- DATA_WIDTH, 32, width of a register value.
- ADDR_WIDTH, 5, width of a register index.
- START_REG, 0, first register index dumped.
- END_REG, 31, last register index dumped. Must satisfy END_REG >= START_REG.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump. Ignored while busy=1.
- abort  input  1  synchronous cancel of a dump in progress.
- rd_addr  output  ADDR_WIDTH  address to the regfile read port (read_reg1/read_reg2 side).
- rd_data  input  DATA_WIDTH  regfile read data. Combinational: valid in the same cycle as rd_addr.
- out_valid  output  1  out_index/out_data hold a word.
- out_ready  input  1  the consumer accepts the word this cycle.
- out_index  output  ADDR_WIDTH  register index of the current word.
- out_data  output  DATA_WIDTH  register value of the current word.
- busy  output  1  a dump is in progress.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=1 at a clock edge, in any state):
  - state=IDLE, cnt=START_REG.
  - out_valid=0, out_index=0, out_data=0, busy=0, done=0, rd_addr=0.
  - An in-flight word is dropped and done is not pulsed.
- FSM states: IDLE, READ, SEND.
- IDLE:
  - busy=0, rd_addr=0.
  - start=1 -> cnt<=START_REG, go to READ.
- READ (exactly one cycle):
  - busy=1, rd_addr=cnt.
  - On the edge: out_data<=rd_data, out_index<=cnt, out_valid<=1, go to SEND.
- SEND:
  - busy=1, rd_addr=cnt.
  - out_valid, out_index and out_data are held stable until out_valid&&out_ready.
  - On handshake with cnt==END_REG: out_valid<=0, done<=1 for the next cycle only, go to IDLE.
  - On handshake otherwise: out_valid<=0, cnt<=cnt+1, go to READ.
- Throughput and latency:
  - Best case is one word per 2 cycles.
  - The first out_valid appears 2 cycles after the edge that samples start.
- Capture timing: the value dumped is rd_data as sampled on the READ-cycle edge. A regfile write to the same register on that same edge is not visible; the value before the write is dumped.
- Counter: cnt never increments past END_REG. With START_REG==END_REG exactly one word is emitted.
- abort:
  - abort=1 in READ or SEND -> IDLE on the next edge, out_valid<=0, no done pulse.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start is ignored.
- start while busy is ignored; it is not queued.
- Priority order: rst > abort > handshake/start.
- done and out_valid are never high in the same cycle.
- busy is combinational from state: busy = (state != IDLE).

Test Plan:
1. Full dump of r1-r3, no backpressure:
   - Stimulus: START_REG=1, END_REG=3; regfile preloaded r1=0x00001511, r2=0x00000123, r3=0x00000312; out_ready=1; start pulsed in cycle 0.
   - Required: out_valid in cycles 2, 4, 6 with (1,0x1511), (2,0x123), (3,0x312); done=1 in cycle 7 only; busy=1 in cycles 1-6.
2. Backpressure:
   - Stimulus: same setup, out_ready held 0 for 5 cycles while the first word is presented.
   - Required: out_index=1 and out_data=0x1511 are stable with out_valid=1 throughout; rd_addr stays 1; the sequence then completes as in scenario 1, shifted by 5 cycles.
3. Write during dump:
   - Stimulus: r2 is written with 0xDEADBEEF on the READ edge for index 2.
   - Required: the emitted word is (2,0x00000123).
   - Stimulus: a second dump is run afterwards.
   - Required: the word emitted is (2,0xDEADBEEF).
4. abort, start-while-busy and reset mid-dump:
   - Stimulus: abort while in SEND for index 2.
   - Required: next cycle out_valid=0, busy=0, and done is never asserted.
   - Stimulus: start pulsed while busy.
   - Required: no restart; exactly 3 words are emitted.
   - Stimulus: rst=1 mid-dump.
   - Required: all outputs are 0 on the next cycle.
5. Single-register range:
   - Stimulus: START_REG=END_REG=0, regfile r0=0.
   - Required: exactly one word (0,0x00000000), then done pulses once.
6. Full default range:
   - Stimulus: START_REG=0, END_REG=31, each register rN preloaded with N*0x01010101, out_ready toggling every cycle.
   - Required: 32 words in index order 0..31 with matching data and no repeated or skipped index; done pulses once.
